// File: rtl/cleared_mem_pkg.sv
// Shared definitions for cleared_mem: clear-engine state encoding and the
// default geometry (entry width, entry count, lowest legal address).
package cleared_mem_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 31;
  localparam int DEF_BASE  = 2;

endpackage

// File: rtl/cleared_mem.sv
// cleared_mem: a small RAM whose legal addresses are BASE..BASE+DEPTH-1.
// A clear engine walks every entry (one per cycle) after reset and on request.
// Reads have one cycle of latency; out-of-range reads flag OUT_rdErr, and
// in-range reads during a clear return 0 because the clear is treated as
// already complete. Writes during a clear, or outside the range, are dropped.
//
// Strobe semantics: IN_wrEn and IN_rdEn are single-cycle requests with no
// back-pressure; every IN_rdEn produces exactly one OUT_rdValid cycle one
// cycle later (unless a reset intervenes), and OUT_rdData/OUT_rdErr are 0
// whenever OUT_rdValid is 0.
//
// Build option: define CLEARED_MEM_FWD_EN to forward same-cycle write data
// to a read of the same address; otherwise such a read returns the old entry.
module cleared_mem
  import cleared_mem_pkg::*;
#(
  parameter int  WIDTH = DEF_WIDTH,
  parameter int  DEPTH = DEF_DEPTH,
  parameter int  BASE  = DEF_BASE,
  localparam int AW    = $clog2(BASE + DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IN_wrEn,
  input  logic [AW-1:0]    IN_wrAddr,
  input  logic [WIDTH-1:0] IN_wrData,
  input  logic             IN_rdEn,
  input  logic [AW-1:0]    IN_rdAddr,
  output logic [WIDTH-1:0] OUT_rdData,
  output logic             OUT_rdValid,
  output logic             OUT_rdErr,
  input  logic             IN_clrReq,
  output logic             OUT_busy,
  output logic             OUT_clrDone,
  output state_e           OUT_dbgState
);

  localparam int            LAST = BASE + DEPTH - 1;
  localparam logic [AW-1:0] LO_A = AW'(BASE);
  localparam logic [AW-1:0] HI_A = AW'(LAST);

  logic [WIDTH-1:0] mem [BASE:LAST];

  state_e           state_q, state_d;
  logic [AW-1:0]    clr_ptr_q, clr_ptr_d;
  logic             clr_done_q, clr_done_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_err_q, rd_err_d;

  logic             wr_in_range, rd_in_range, wr_ok;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  // Address decode and user-write qualification (only honoured when idle).
  always_comb begin
    wr_in_range = (IN_wrAddr >= LO_A) && (IN_wrAddr <= HI_A);
    rd_in_range = (IN_rdAddr >= LO_A) && (IN_rdAddr <= HI_A);
    wr_ok       = IN_wrEn && wr_in_range && (state_q == IDLE);
  end

  // Clear engine next state and the single memory write port arbitration.
  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    clr_done_d = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = IN_wrAddr;
    mem_wdata  = IN_wrData;
    case (state_q)
      IDLE: begin
        if (wr_ok) begin
          mem_we = 1'b1;
        end
        if (IN_clrReq) begin
          state_d   = CLEAR;
          clr_ptr_d = LO_A;
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        if (IN_clrReq) begin
          // Restarted pass: the aborted one never reports completion.
          clr_ptr_d = LO_A;
        end else if (clr_ptr_q == HI_A) begin
          state_d    = IDLE;
          clr_done_d = 1'b1;
        end else begin
          clr_ptr_d = clr_ptr_q + AW'(1);
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_ptr_d = LO_A;
      end
    endcase
  end

  // Read response: error for out-of-range, zero while clearing, else the entry.
  always_comb begin
    rd_valid_d = IN_rdEn;
    rd_data_d  = '0;
    rd_err_d   = 1'b0;
    if (IN_rdEn) begin
      if (!rd_in_range) begin
        rd_err_d = 1'b1;
      end else if (state_q == IDLE) begin
        rd_data_d = mem[IN_rdAddr];
`ifdef CLEARED_MEM_FWD_EN
        if (wr_ok && (IN_wrAddr == IN_rdAddr)) begin
          rd_data_d = IN_wrData;
        end
`endif
      end
    end
  end

  // Control and read-response registers; reset starts a fresh clear pass.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= CLEAR;
      clr_ptr_q  <= LO_A;
      clr_done_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      clr_done_q <= clr_done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_err_q   <= rd_err_d;
    end
  end

  // Storage array; contents are not reset, the clear engine zeroes them.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign OUT_rdData   = rd_data_q;
  assign OUT_rdValid  = rd_valid_q;
  assign OUT_rdErr    = rd_err_q;
  assign OUT_busy     = (state_q == CLEAR);
  assign OUT_clrDone  = clr_done_q;
  assign OUT_dbgState = state_q;

endmodule

// File: tb/tb_cleared_mem.sv
// Testbench for cleared_mem: directed steps plus a randomized traffic phase
// checked against an array-based reference of the memory contents.
module tb_cleared_mem;

  localparam int WIDTH = 8;
  localparam int DEPTH = 31;
  localparam int BASE  = 2;
  localparam int LAST  = BASE + DEPTH - 1;
  localparam int AW    = $clog2(BASE + DEPTH);
`ifdef CLEARED_MEM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // Clock / reset and DUT signals
  logic                   clk = 1'b0;
  logic                   rst;
  logic                   IN_wrEn;
  logic [AW-1:0]          IN_wrAddr;
  logic [WIDTH-1:0]       IN_wrData;
  logic                   IN_rdEn;
  logic [AW-1:0]          IN_rdAddr;
  logic [WIDTH-1:0]       OUT_rdData;
  logic                   OUT_rdValid;
  logic                   OUT_rdErr;
  logic                   IN_clrReq;
  logic                   OUT_busy;
  logic                   OUT_clrDone;
  cleared_mem_pkg::state_e OUT_dbgState;

  always #5 clk = ~clk;

  cleared_mem dut (
    .clk          (clk),
    .rst          (rst),
    .IN_wrEn      (IN_wrEn),
    .IN_wrAddr    (IN_wrAddr),
    .IN_wrData    (IN_wrData),
    .IN_rdEn      (IN_rdEn),
    .IN_rdAddr    (IN_rdAddr),
    .OUT_rdData   (OUT_rdData),
    .OUT_rdValid  (OUT_rdValid),
    .OUT_rdErr    (OUT_rdErr),
    .IN_clrReq    (IN_clrReq),
    .OUT_busy     (OUT_busy),
    .OUT_clrDone  (OUT_clrDone),
    .OUT_dbgState (OUT_dbgState)
  );

  // Scoreboard state: reference contents of every addressable location
  int               tests = 0;
  int               fails = 0;
  logic [WIDTH-1:0] ref_mem [0:(1<<AW)-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input int a);
    return (a >= BASE) && (a <= LAST);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    IN_wrEn   = 1'b0;
    IN_wrAddr = '0;
    IN_wrData = '0;
    IN_rdEn   = 1'b0;
    IN_rdAddr = '0;
    IN_clrReq = 1'b0;
  endtask

  task automatic model_clear();
    for (int a = BASE; a <= LAST; a++) ref_mem[a] = '0;
  endtask

  // Driver tasks
  task automatic do_write(input int a, input logic [WIDTH-1:0] d);
    IN_wrEn   = 1'b1;
    IN_wrAddr = AW'(a);
    IN_wrData = d;
    tick();
    IN_wrEn   = 1'b0;
    if (in_range(a)) ref_mem[a] = d;
  endtask

  task automatic do_read(input string tag, input int a, input logic [WIDTH-1:0] exp_d,
                         input logic exp_e);
    IN_rdEn   = 1'b1;
    IN_rdAddr = AW'(a);
    tick();
    IN_rdEn   = 1'b0;
    check({tag, "_valid"}, OUT_rdValid, 1'b1);
    check({tag, "_data"},  OUT_rdData,  exp_d);
    check({tag, "_err"},   OUT_rdErr,   exp_e);
  endtask

  task automatic check_all(input string tag);
    for (int a = BASE; a <= LAST; a++) do_read(tag, a, ref_mem[a], 1'b0);
  endtask

  // Counts busy cycles and done pulses from the current sample onward.
  task automatic measure_clear(output int bc, output int dc);
    bc = 0;
    dc = 0;
    for (int i = 0; i < 80; i++) begin
      if (OUT_busy) bc++;
      if (OUT_clrDone) dc++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before the bench finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, dc;
    int wa, ra;
    logic we, re;
    logic [WIDTH-1:0] wd, exp_d;
    logic exp_e;

    for (int a = 0; a < (1<<AW); a++) ref_mem[a] = 'x;

    // Reset held two cycles, with a read strobe that must be cancelled
    idle_inputs();
    rst       = 1'b0;
    IN_rdEn   = 1'b1;
    IN_rdAddr = AW'(BASE);
    tick();
    tick();
    IN_rdEn = 1'b0;
    check("rst_valid", OUT_rdValid, 1'b0);
    check("rst_data",  OUT_rdData,  '0);
    check("rst_err",   OUT_rdErr,   1'b0);
    check("rst_done",  OUT_clrDone, 1'b0);
    check("rst_busy",  OUT_busy,    1'b1);
    check("rst_state", OUT_dbgState, cleared_mem_pkg::CLEAR);

    rst = 1'b1;
    measure_clear(bc, dc);
    model_clear();
    check("boot_busy_cycles", bc, 31);
    check("boot_done_pulses", dc, 1);
    check("boot_idle", OUT_busy, 1'b0);
    do_read("boot_rd2", 2, 8'h00, 1'b0);
    tick();
    check("rv_drop_valid", OUT_rdValid, 1'b0);
    check("rv_drop_data",  OUT_rdData,  '0);
    check_all("boot_all");

    // Write then read back at the top address
    do_write(32, 8'hA5);
    do_read("rd32", 32, 8'hA5, 1'b0);
    tick();
    check("rd32_after_valid", OUT_rdValid, 1'b0);

    // Out-of-range accesses
    do_read("oor1",  1,  8'h00, 1'b1);
    do_read("oor33", 33, 8'h00, 1'b1);
    do_read("oor0",  0,  8'h00, 1'b1);
    do_read("oor63", 63, 8'h00, 1'b1);
    do_write(1, 8'hFF);
    check_all("after_oor_wr");

    // Same-cycle write and read at one address
    do_write(7, 8'h22);
    IN_wrEn   = 1'b1;
    IN_wrAddr = AW'(7);
    IN_wrData = 8'h11;
    IN_rdEn   = 1'b1;
    IN_rdAddr = AW'(7);
    tick();
    idle_inputs();
    ref_mem[7] = 8'h11;
    check("fwd_data", OUT_rdData, FWD ? 8'h11 : 8'h22);
    check("fwd_err",  OUT_rdErr,  1'b0);
    do_read("fwd_follow", 7, 8'h11, 1'b0);

    // Randomized idle traffic against the reference array
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      wa = $urandom_range(0, 40);
      wd = WIDTH'($urandom_range(0, 255));
      re = 1'($urandom_range(0, 1));
      ra = (n % 4 == 0) ? wa : $urandom_range(0, 40);
      exp_d = '0;
      exp_e = 1'b0;
      if (re) begin
        if (!in_range(ra)) exp_e = 1'b1;
        else if (FWD && we && in_range(wa) && wa == ra) exp_d = wd;
        else exp_d = ref_mem[ra];
      end
      if (we && in_range(wa)) ref_mem[wa] = wd;
      IN_wrEn   = we;
      IN_wrAddr = AW'(wa);
      IN_wrData = wd;
      IN_rdEn   = re;
      IN_rdAddr = AW'(ra);
      tick();
      check("rnd_valid", OUT_rdValid, re);
      check("rnd_data",  OUT_rdData,  exp_d);
      check("rnd_err",   OUT_rdErr,   exp_e);
    end
    idle_inputs();
    check_all("rnd_all");

    // Fill, clear, restart the clear ten cycles in; write and read while busy
    for (int a = BASE; a <= LAST; a++) do_write(a, 8'h3C);
    check_all("fill");
    IN_clrReq = 1'b1;
    tick();
    bc = 0;
    dc = 0;
    for (int i = 0; i < 90; i++) begin
      if (OUT_busy) bc++;
      if (OUT_clrDone) dc++;
      if (i == 5) begin
        check("busy_rd_valid", OUT_rdValid, 1'b1);
        check("busy_rd_data",  OUT_rdData,  '0);
        check("busy_rd_err",   OUT_rdErr,   1'b0);
      end
      IN_clrReq = (i == 9);
      IN_wrEn   = (i == 3);
      IN_wrAddr = AW'(5);
      IN_wrData = 8'h77;
      IN_rdEn   = (i == 4);
      IN_rdAddr = AW'(7);
      tick();
    end
    idle_inputs();
    model_clear();
    check("restart_busy_cycles", bc, 41);
    check("restart_done_pulses", dc, 1);
    do_read("busy_wr_dropped", 5, 8'h00, 1'b0);
    check_all("after_restart");

    // Reset in the middle of a clear with a read in flight
    do_write(10, 8'h5A);
    IN_clrReq = 1'b1;
    tick();
    IN_clrReq = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst       = 1'b0;
    IN_rdEn   = 1'b1;
    IN_rdAddr = AW'(10);
    tick();
    IN_rdEn = 1'b0;
    check("midrst_valid", OUT_rdValid, 1'b0);
    check("midrst_data",  OUT_rdData,  '0);
    check("midrst_busy",  OUT_busy,    1'b1);
    rst = 1'b1;
    measure_clear(bc, dc);
    model_clear();
    check("midrst_busy_cycles", bc, 31);
    check("midrst_done_pulses", dc, 1);
    check_all("after_midrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cleared_mem.md
CLEARED_MEM -- requirements
Module: cleared_mem

Interface
REQ-001 Parameter WIDTH, default 8: data bits per entry.
REQ-002 Parameter DEPTH, default 31: number of entries.
REQ-003 Parameter BASE, default 2: lowest legal address; legal range BASE..BASE+DEPTH-1.
REQ-004 Localparam AW = $clog2(BASE+DEPTH) SHALL set all address port widths.
REQ-005 Port clk, input, 1: the only clock; all state SHALL update on its rising edge.
REQ-006 Port rst, input, 1: reset, synchronous and active-low.
REQ-007 Port IN_wrEn, input, 1: write strobe.
REQ-008 Port IN_wrAddr, input, AW: write address.
REQ-009 Port IN_wrData, input, WIDTH: write data.
REQ-010 Port IN_rdEn, input, 1: read strobe.
REQ-011 Port IN_rdAddr, input, AW: read address.
REQ-012 Port OUT_rdData, output, WIDTH: read data.
REQ-013 Port OUT_rdValid, output, 1: OUT_rdData valid this cycle.
REQ-014 Port OUT_rdErr, output, 1: the returned read was out of range.
REQ-015 Port IN_clrReq, input, 1: request a full clear.
REQ-016 Port OUT_busy, output, 1: clear engine active.
REQ-017 Port OUT_clrDone, output, 1: single-cycle pulse when a clear completes.

Function
REQ-018 FSM states: IDLE, CLEAR; a pointer clrPtr (AW bits) SHALL walk BASE..BASE+DEPTH-1.
REQ-019 CLEAR: one entry zeroed per cycle at clrPtr, then clrPtr+1; clear SHALL take exactly DEPTH cycles.
REQ-020 CLEAR, clrPtr = BASE+DEPTH-1: zero that entry, go to IDLE, assert OUT_clrDone in the next cycle only.
REQ-021 IDLE with IN_clrReq=1: enter CLEAR with clrPtr=BASE; OUT_busy=1 from the next cycle.
REQ-022 IN_clrReq=1 during CLEAR: restart, clrPtr=BASE next cycle; no OUT_clrDone for the aborted pass.
REQ-023 OUT_busy SHALL be 1 exactly while state is CLEAR.
REQ-024 Write in IDLE, IN_wrEn=1, address in range: store IN_wrData at the next edge.
REQ-025 Writes with an out-of-range address, or issued while OUT_busy=1, SHALL be dropped silently.
REQ-026 Read latency is 1 cycle: IN_rdEn=1 in cycle t gives OUT_rdValid=1 in cycle t+1 only.
REQ-027 In-range read in IDLE: OUT_rdData = stored entry, OUT_rdErr=0.
REQ-028 Out-of-range read: OUT_rdData=0, OUT_rdErr=1.
REQ-029 In-range read while OUT_busy=1: OUT_rdData=0, OUT_rdErr=0; the clear is treated as logically complete.
REQ-030 OUT_rdData and OUT_rdErr SHALL be 0 whenever OUT_rdValid=0.

Reset
REQ-031 rst=0 at an edge: state=CLEAR, clrPtr=BASE, OUT_rdValid=0, OUT_rdData=0, OUT_rdErr=0, OUT_clrDone=0.
REQ-032 After rst deasserts, OUT_busy=1 for DEPTH cycles, then one OUT_clrDone pulse; all entries then read 0.
REQ-033 rst=0 mid-clear or mid-read SHALL restart the clear from BASE and cancel any pending read response.

Configuration
REQ-034 Macro CLEARED_MEM_FWD_EN defined: an IDLE read and an in-range write to the same address in the same cycle SHALL return IN_wrData.
REQ-035 Macro CLEARED_MEM_FWD_EN undefined: the same case SHALL return the old entry; the new data is visible from the following read.

Structure
REQ-036 Shared package cleared_mem_pkg SHALL hold the FSM state enum (IDLE, CLEAR) and the default parameter constants.
REQ-037 No sub-module; storage is an inferred array indexed BASE..BASE+DEPTH-1.

Verification
REQ-038 Release rst after 2 cycles -> OUT_busy=1 for 31 cycles, OUT_clrDone pulses once, then a read of addr 2 returns 0x00 with OUT_rdErr=0.
REQ-039 IDLE: write 0xA5 to addr 32, read addr 32 next cycle -> OUT_rdValid=1, OUT_rdData=0xA5, one cycle after the read strobe.
REQ-040 Read addr 1 and read addr 33 -> OUT_rdErr=1, OUT_rdData=0; a write of 0xFF to addr 1 leaves all entries unchanged.
REQ-041 Fill all entries with 0x3C, pulse IN_clrReq, pulse it again 10 cycles later -> OUT_busy holds 41 cycles total, one OUT_clrDone, all reads return 0.
REQ-042 Write 0x77 to addr 5 while OUT_busy=1 -> dropped; a read of addr 5 after OUT_clrDone returns 0.
REQ-043 Same-cycle write 0x11 and read at addr 7 holding 0x22 -> returns 0x11 with CLEARED_MEM_FWD_EN defined, 0x22 without it.
